// File: rtl/debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debouncer_pkg
// Brief    : Shared state encoding and default qualification length.
// Revision : 1.0
// ============================================================================
package debouncer_pkg;

   // 10 ms at a 12 MHz clock.
   localparam int unsigned c_stable_cycles_dflt = 120000;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } dbnc_state_e;

endpackage : debouncer_pkg
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module   : debouncer
// Brief    : Accepts a new level after StableCycles consecutive differing
//            samples; emits one-cycle rise/fall pulses on accepted changes.
// Revision : 1.0
// ============================================================================
module debouncer
   import debouncer_pkg::*;
#(
   parameter int unsigned StableCycles = c_stable_cycles_dflt,
   parameter logic        InitialValue = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   if (StableCycles < 2) begin : g_bad_stable_cycles
      $error("debouncer: StableCycles must be >= 2");
   end

   localparam int unsigned          c_CNT_W     = $clog2(StableCycles);
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0]   c_CNT_LAST  = c_CNT_W'(StableCycles - 1);
   localparam dbnc_state_e          c_RST_STATE = InitialValue ? STABLE_HI : STABLE_LO;

   dbnc_state_e          r_state;
   dbnc_state_e          w_state_next;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_CNT_W-1:0]   w_count_next;
   logic                 r_level;
   logic                 w_level_next;
   logic                 r_rise;
   logic                 w_rise_next;
   logic                 r_fall;
   logic                 w_fall_next;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= c_RST_STATE;
         r_count <= '0;
         r_level <= InitialValue;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_level <= w_level_next;
         r_rise  <= w_rise_next;
         r_fall  <= w_fall_next;
      end
   end

   // The first differing sample already counts as one, so the change lands
   // on the StableCycles-th consecutive differing sample.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_rise_next  = 1'b0;
      w_fall_next  = 1'b0;
      case (r_state)
         STABLE_LO: begin
            if (sig_i) begin
               w_state_next = WAIT_HI;
               w_count_next = c_CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!sig_i) begin
               w_state_next = STABLE_LO;
               w_count_next = '0;
            end else if (r_count == c_CNT_LAST) begin
               w_state_next = STABLE_HI;
               w_count_next = '0;
               w_rise_next  = 1'b1;
            end else begin
               w_count_next = r_count + c_CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!sig_i) begin
               w_state_next = WAIT_LO;
               w_count_next = c_CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (sig_i) begin
               w_state_next = STABLE_HI;
               w_count_next = '0;
            end else if (r_count == c_CNT_LAST) begin
               w_state_next = STABLE_LO;
               w_count_next = '0;
               w_fall_next  = 1'b1;
            end else begin
               w_count_next = r_count + c_CNT_ONE;
            end
         end
         default: begin
            w_state_next = c_RST_STATE;
            w_count_next = '0;
         end
      endcase
   end

   assign w_level_next = (w_state_next == STABLE_HI) || (w_state_next == WAIT_LO);

   assign level_o = r_level;
   assign rise_o  = r_rise;
   assign fall_o  = r_fall;

endmodule : debouncer
`default_nettype wire

// File: tb/tb_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_debouncer
// Brief    : Directed bench for debouncer (StableCycles=4, InitialValue=1).
// Revision : 1.0
// ============================================================================
module tb_debouncer;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic sig_i = 1'b1;
   logic level_o;
   logic rise_o;
   logic fall_o;

   int n_checks = 0;
   int n_fail   = 0;

   debouncer #(
      .StableCycles (4),
      .InitialValue (1'b1)
   ) u_dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sig_i   (sig_i),
      .level_o (level_o),
      .rise_o  (rise_o),
      .fall_o  (fall_o)
   );

   always #5 clk_i = ~clk_i;

   // Observed/expected are {level_o, rise_o, fall_o}.
   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got lvl/rise/fall=%b expected %b", tag, got, exp);
      end
   endtask

   // Present one sample, clock it in, check the registered outputs.
   task automatic step(input logic s, input logic [2:0] exp, input string tag);
      sig_i = s;
      @(posedge clk_i);
      #1;
      check(tag, {level_o, rise_o, fall_o}, exp);
   endtask

   // Reset with sig_i high; returns #1 after an edge with rst_i released.
   task automatic do_reset();
      sig_i = 1'b1;
      rst_i = 1'b1;
      #2;
      check("reset_state", {level_o, rise_o, fall_o}, 3'b100);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      // Reset release with a high input: idle for 20 cycles.
      @(posedge clk_i);
      #1;
      do_reset();
      for (int i = 1; i <= 20; i++) step(1'b1, 3'b100, $sformatf("idle_%0d", i));

      // Low held from edge 10: fall at edge 13 only.
      do_reset();
      for (int i = 1; i <= 9; i++) step(1'b1, 3'b100, $sformatf("pre_low_%0d", i));
      step(1'b0, 3'b100, "low_e10");
      step(1'b0, 3'b100, "low_e11");
      step(1'b0, 3'b100, "low_e12");
      step(1'b0, 3'b001, "low_e13_fall");
      step(1'b0, 3'b000, "low_e14_nofall");
      step(1'b0, 3'b000, "low_e15_hold");

      // Three-cycle glitch rejected, then a four-cycle low accepted.
      do_reset();
      step(1'b0, 3'b100, "glitch3_1");
      step(1'b0, 3'b100, "glitch3_2");
      step(1'b0, 3'b100, "glitch3_3");
      step(1'b1, 3'b100, "glitch3_back_hi");
      step(1'b0, 3'b100, "low4_1");
      step(1'b0, 3'b100, "low4_2");
      step(1'b0, 3'b100, "low4_3");
      step(1'b0, 3'b001, "low4_4_fall");
      step(1'b0, 3'b000, "low4_5");

      // Toggle every cycle: no level change, no pulses.
      do_reset();
      for (int i = 0; i < 100; i++) step(logic'(i[0]), 3'b100, $sformatf("toggle_%0d", i));

      // Pending change aborted by reset; full qualification afterwards.
      do_reset();
      step(1'b0, 3'b100, "prerst_low_1");
      step(1'b0, 3'b100, "prerst_low_2");
      sig_i = 1'b0;
      rst_i = 1'b1;
      #2;
      check("midwait_rst_async", {level_o, rise_o, fall_o}, 3'b100);
      @(posedge clk_i);
      #1;
      check("midwait_rst_held", {level_o, rise_o, fall_o}, 3'b100);
      rst_i = 1'b0;
      step(1'b0, 3'b100, "postrst_low_1");
      step(1'b0, 3'b100, "postrst_low_2");
      step(1'b0, 3'b100, "postrst_low_3");
      step(1'b0, 3'b001, "postrst_low_4_fall");
      step(1'b0, 3'b000, "postrst_low_5");

      // Press then release, 10 cycles each: fall at 4, rise at 14.
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         logic       s;
         logic [2:0] e;
         s = (i > 10);
         if (i < 4)       e = 3'b100;
         else if (i == 4) e = 3'b001;
         else if (i < 14) e = 3'b000;
         else if (i == 14) e = 3'b110;
         else             e = 3'b100;
         step(s, e, $sformatf("press_rel_%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_debouncer
`default_nettype wire
